// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM write arbiter: FSM encoding, requester IDs,
// frame-buffer index constants and the camera triple-buffer rotation helper.
package sdram_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // Requester IDs as carried on grant_sd
    localparam logic REQ_CAM = 1'b0;
    localparam logic REQ_SD  = 1'b1;

    // Frame buffer indices: camera rotates over 0..CAM_FRAMES-1, SD owns the last slot
    localparam logic [1:0]  SD_FRAME_INDEX = 2'd3;
    localparam int unsigned CAM_FRAMES     = 3;

    // Pick the camera index that is neither the current write nor the current read index
    function automatic logic [1:0] next_cam_index(input logic [1:0] cw, input logic [1:0] rd);
        return 2'(CAM_FRAMES) - cw - rd;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser between camera and SD requests with its
// last-grant register. The choice is combinational; commit records the winner.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_cam,
    input  logic req_sd,
    input  logic commit,
    output logic valid_c,
    output logic grant_sd_c
);
    import sdram_arb_pkg::*;

    logic last_sd_q;
    logic last_sd_d;

    // Winner selection: on a tie, the side not granted last time wins
    always_comb begin
        valid_c    = req_cam | req_sd;
        grant_sd_c = req_sd;
        if (req_cam && req_sd) begin
            grant_sd_c = (last_sd_q == REQ_CAM);
        end
        last_sd_d = commit ? grant_sd_c : last_sd_q;
    end

    // Last-grant register; reset to SD so the camera wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sd_q <= REQ_SD;
        end else begin
            last_sd_q <= last_sd_d;
        end
    end

endmodule

// File: rtl/sdram_wr_arb.sv
// SDRAM write-port arbiter between a camera and an SD-card source.
// Runs IDLE -> REQ -> BURST -> IDLE, triple-buffers camera frames over
// indices 0..2 and reserves index 3 for SD bursts.
// Optional burst watchdog enabled by defining SDRAM_WR_ARB_TIMEOUT_EN.
module sdram_wr_arb #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmos_req,
    input  logic       sd_req,
    input  logic       cmos_frame_done,
    input  logic       wr_req_ack,
    input  logic       wr_done,
    output logic       wr_req,
    output logic       cmos_ack,
    output logic       sd_ack,
    output logic       grant_sd,
    output logic [1:0] write_addr_index,
    output logic [1:0] read_addr_index,
    output logic       busy,
    output logic       timeout_err
);
    import sdram_arb_pkg::*;

    logic [1:0] state_q,   state_d;
    logic       wr_req_q,  wr_req_d;
    logic       cmos_ack_q, cmos_ack_d;
    logic       sd_ack_q,  sd_ack_d;
    logic       grant_sd_q, grant_sd_d;
    logic [1:0] waddr_q,   waddr_d;
    logic [1:0] cw_q,      cw_d;
    logic [1:0] rd_q,      rd_d;
    logic       pending_q, pending_d;
    logic       busy_q,    busy_d;

    logic       arb_valid;
    logic       arb_sd;
    logic       arb_commit;
    logic       tmo_hit;
    logic       cam_busy;
    logic       rotate;

    assign arb_commit = (state_q == ST_IDLE) && arb_valid;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .req_cam    (cmos_req),
        .req_sd     (sd_req),
        .commit     (arb_commit),
        .valid_c    (arb_valid),
        .grant_sd_c (arb_sd)
    );

`ifdef SDRAM_WR_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    // Watchdog: counts cycles spent in REQ/BURST, fires on the TIMEOUT-th one
    always_comb begin
        tmo_hit   = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
        tmo_cnt_d = '0;
        if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        tmo_err_d = tmo_hit;
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state, frame rotation and registered-output logic
    always_comb begin
        state_d    = state_q;
        grant_sd_d = grant_sd_q;
        waddr_d    = waddr_q;
        cw_d       = cw_q;
        rd_d       = rd_q;
        pending_d  = pending_q;
        cmos_ack_d = 1'b0;
        sd_ack_d   = 1'b0;
        rotate     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d    = ST_REQ;
                    grant_sd_d = arb_sd;
                end
            end
            ST_REQ: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (wr_req_ack) begin
                    state_d = ST_BURST;
                    if (grant_sd_q) begin
                        sd_ack_d = 1'b1;
                    end else begin
                        cmos_ack_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (tmo_hit || wr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A camera burst in flight defers rotation until IDLE entry; extra pulses collapse
        cam_busy = (state_q != ST_IDLE) && !grant_sd_q;
        if (cam_busy) begin
            if (state_d == ST_IDLE) begin
                rotate    = pending_q | cmos_frame_done;
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q | cmos_frame_done;
            end
        end else begin
            rotate = cmos_frame_done;
        end

        if (rotate) begin
            rd_d = cw_q;
            cw_d = next_cam_index(cw_q, rd_q);
        end

        // Burst index only tracks in IDLE so it is frozen from REQ entry to IDLE return
        if (state_q == ST_IDLE) begin
            waddr_d = grant_sd_d ? SD_FRAME_INDEX : cw_d;
        end

        wr_req_d = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_req_q   <= 1'b0;
            cmos_ack_q <= 1'b0;
            sd_ack_q   <= 1'b0;
            grant_sd_q <= 1'b0;
            waddr_q    <= 2'd0;
            cw_q       <= 2'd0;
            rd_q       <= 2'd1;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_req_q   <= wr_req_d;
            cmos_ack_q <= cmos_ack_d;
            sd_ack_q   <= sd_ack_d;
            grant_sd_q <= grant_sd_d;
            waddr_q    <= waddr_d;
            cw_q       <= cw_d;
            rd_q       <= rd_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_req           = wr_req_q;
    assign cmos_ack         = cmos_ack_q;
    assign sd_ack           = sd_ack_q;
    assign grant_sd         = grant_sd_q;
    assign write_addr_index = waddr_q;
    assign read_addr_index  = rd_q;
    assign busy             = busy_q;

endmodule
